decode_rename_sched: RTL and testbench
======================================

Name: decode_rename_sched

Overview:
- Scheduler between the two decoders and the 2-wide rename stage.
- Each cycle it accepts up to 4 uOPs in program order: decoder0 uOP0, uOP1, then decoder1 uOP0, uOP1.
- It compacts out invalid slots, buffers the valid uOPs in a circular queue, and issues up to 2 in-order uOPs per cycle to rename.
- It raises a pause request to the front end when it cannot guarantee room for a full 4-uOP group.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 4.
- UOP_W, 128, width of one packed uOP bundle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  4  per-slot valid. [0]=dec0.uOP0, [1]=dec0.uOP1, [2]=dec1.uOP0, [3]=dec1.uOP1.
- in_uop  in  4*UOP_W  slot payloads; slot k occupies bits [k*UOP_W +: UOP_W].
- pause_req  out  1  front-end stall request; equals !in_ready.
- rename_pause  in  1  rename stage cannot accept this cycle.
- out_valid0  out  1  rename slot 0 valid.
- out_uop0  out  UOP_W  rename slot 0 payload (oldest).
- out_valid1  out  1  rename slot 1 valid.
- out_uop1  out  UOP_W  rename slot 1 payload (second oldest).
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- State:
  - head and tail pointers, each $clog2(DEPTH) bits; they wrap modulo DEPTH with natural overflow.
  - count register.
  - mem[DEPTH] of UOP_W.
- Reset (async, rst=1):
  - head=tail=count=0.
  - Outputs: out_valid0=out_valid1=0, pause_req=0, occupancy=0.
  - Memory contents are not reset.
  - Reset mid-operation drops all queued uOPs immediately, without waiting for a clock edge.
- in_ready = (DEPTH - count) >= 4. It uses the registered count, so space freed by a same-cycle dequeue is not credited.
- pause_req = !in_ready. It is combinational from registers only and has no dependency on in_valid.
- Enqueue (posedge):
  - Occurs when in_ready && !flush.
  - Let n = popcount(in_valid), 0..4.
  - The valid slots are written in ascending slot order to mem[tail], mem[tail+1], ... with invalid slots skipped. Example: in_valid=4'b1010 writes slot1 to tail and slot3 to tail+1.
  - tail += n.
  - If in_ready=0, the inputs are ignored. Upstream holds them because pause_req was asserted.
- Issue (combinational):
  - out_valid0 = count>=1 and out_uop0 = mem[head].
  - out_valid1 = count>=2 and out_uop1 = mem[head+1] (wrapping).
  - out_valid1 is never 1 while out_valid0 is 0.
- Dequeue (posedge):
  - d = rename_pause ? 0 : (out_valid0 + out_valid1).
  - head += d.
  - Rename consumes both presented valid slots whenever rename_pause=0. There is no partial accept.
- count_next = count + n_accepted - d. Simultaneous enqueue and dequeue are legal, and count never exceeds DEPTH.
- Flush (posedge):
  - head=tail=count=0.
  - Takes priority over enqueue and dequeue in the same cycle.
  - Outputs are 0 in the cycle after flush.
- Latency: a uOP enqueued at edge t is visible on out_* in cycle t+1 at the earliest.
- Order: strict program order; the queue is FIFO across cycles and ascending-slot within a cycle.
- Empty: out_valid0=out_valid1=0, and rename_pause has no effect.
- Full or near-full:
  - count > DEPTH-4 asserts pause_req.
  - The queue deasserts pause_req in the cycle after the count drops to DEPTH-4 or below.
- Assertions:
  - count <= DEPTH.
  - (tail - head) mod DEPTH == count mod DEPTH.
  - No enqueue while pause_req=1.

Test Plan:
- Burst compaction: reset, rename_pause=0, one cycle in_valid=4'b1111 with uOP IDs 10..13 → cycle+1: out_uop0=10, out_uop1=11, occupancy=4; cycle+2: out 12,13; cycle+3: out_valid0=0.
- Sparse slots: in_valid=4'b0101 (IDs A at slot0, B at slot2), then 4'b1000 (C) → issued order A,B then C; occupancy never exceeds 2.
- Backpressure with DEPTH=8:
  - Hold rename_pause=1 and present 4'b1111 every cycle.
  - After 1 edge: occupancy=4, pause_req=0. After 2 edges: occupancy=8, pause_req=1, and further inputs are ignored.
  - Release rename_pause: occupancy 8→6→4, and pause_req drops when occupancy=4.
- Odd drain: enqueue 3 uOPs (4'b0111) → one cycle issuing 2, then one cycle with out_valid0=1, out_valid1=0 issuing the 3rd.
- Wrap-around: run 20 cycles of random in_valid with random rename_pause → output sequence matches a golden in-order model across pointer wrap, with no loss or duplication.
- Flush and reset: with occupancy=6, assert flush together with in_valid=4'b1111 → next cycle occupancy=0, outputs invalid, flushed inputs not enqueued. Asserting rst asynchronously mid-cycle → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/decode_rename_sched.sv
// Decode-to-rename scheduler: compacts up to four decoded uOPs per cycle into a
// circular queue and issues up to two in-order uOPs per cycle to rename.
module decode_rename_sched #(
   parameter int DEPTH = 8,
   parameter int UOP_W = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [3:0]               in_valid,
   input  logic [4*UOP_W-1:0]       in_uop,
   output logic                     pause_req,
   input  logic                     rename_pause,
   output logic                     out_valid0,
   output logic [UOP_W-1:0]         out_uop0,
   output logic                     out_valid1,
   output logic [UOP_W-1:0]         out_uop1,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    head_reg, tail_reg;
   logic [CW-1:0]    count_reg;
   logic [UOP_W-1:0] mem [DEPTH];

   logic             in_ready;
   logic             enq;
   logic [2:0]       n_valid;
   logic [2:0]       n_acc;
   logic [1:0]       deq;
   logic [AW-1:0]    slot_off [4];
   logic [AW-1:0]    wr_addr  [4];

   // Registered count only: space freed by this cycle's dequeue is not credited.
   assign in_ready  = count_reg <= CW'(DEPTH - 4);
   assign pause_req = !in_ready;
   assign enq       = in_ready && !flush;
   assign n_acc     = enq ? n_valid : 3'd0;

   // Each valid slot lands at tail plus the number of valid slots below it.
   always_comb begin
      n_valid = 3'd0;
      for (int k = 0; k < 4; k++) begin
         slot_off[k] = AW'(n_valid);
         n_valid     = n_valid + {2'b00, in_valid[k]};
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_wr_addr
      assign wr_addr[gi] = tail_reg + slot_off[gi];
   end

   assign out_valid0 = count_reg != '0;
   assign out_valid1 = count_reg >= CW'(2);
   assign out_uop0   = mem[head_reg];
   assign out_uop1   = mem[head_reg + AW'(1)];
   assign occupancy  = count_reg;

   // Rename takes everything presented or nothing at all.
   assign deq = rename_pause ? 2'd0 : ({1'b0, out_valid0} + {1'b0, out_valid1});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_reg + AW'(deq);
         tail_reg  <= tail_reg + AW'(n_acc);
         count_reg <= count_reg + CW'(n_acc) - CW'(deq);
      end
   end

   // Payload storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      if (enq) begin
         for (int k = 0; k < 4; k++) begin
            if (in_valid[k]) begin
               mem[wr_addr[k]] <= in_uop[k*UOP_W +: UOP_W];
            end
         end
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count_reg <= CW'(DEPTH));
   a_ptr_count : assert property (@(posedge clk) disable iff (rst)
      AW'(tail_reg - head_reg) == AW'(count_reg));
   a_no_enq_paused : assert property (@(posedge clk) disable iff (rst)
      pause_req |-> !(enq && (in_valid != 4'b0000)));

endmodule

// File: tb/tb_decode_rename_sched.sv
// Directed bench for decode_rename_sched: a queue-level model checked every
// negative edge, plus literal expectations at the key points of each scenario.
module tb_decode_rename_sched;

   localparam int DEPTH = 8;
   localparam int UOP_W = 128;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   flush = 1'b0;
   logic [3:0]             in_valid = 4'b0000;
   logic [4*UOP_W-1:0]     in_uop = '0;
   logic                   rename_pause = 1'b0;
   logic                   pause_req;
   logic                   out_valid0, out_valid1;
   logic [UOP_W-1:0]       out_uop0, out_uop1;
   logic [$clog2(DEPTH):0] occupancy;

   decode_rename_sched #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_uop       (in_uop),
      .pause_req    (pause_req),
      .rename_pause (rename_pause),
      .out_valid0   (out_valid0),
      .out_uop0     (out_uop0),
      .out_valid1   (out_valid1),
      .out_uop1     (out_uop1),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [UOP_W-1:0] q[$];

   task automatic chk(input string name, input logic [UOP_W-1:0] act, input logic [UOP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the queue contents in program order; outputs follow directly from it.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("occupancy", UOP_W'(occupancy), UOP_W'(q.size()));
         chk("pause_req", UOP_W'(pause_req), UOP_W'(q.size() > DEPTH - 4));
         chk("out_valid0", UOP_W'(out_valid0), UOP_W'(q.size() >= 1));
         chk("out_valid1", UOP_W'(out_valid1), UOP_W'(q.size() >= 2));
         if (q.size() >= 1) chk("out_uop0", out_uop0, q[0]);
         if (q.size() >= 2) chk("out_uop1", out_uop1, q[1]);
      end
   end

   // Drive one cycle of inputs, advance the model across the edge, leave time at edge+1.
   task automatic step(input logic [3:0] v, input int base, input logic rp, input logic fl);
      int  d;
      bit  rdy;
      in_valid     = v;
      rename_pause = rp;
      flush        = fl;
      for (int k = 0; k < 4; k++) in_uop[k*UOP_W +: UOP_W] = UOP_W'(base + k);
      rdy = (DEPTH - q.size()) >= 4;
      d   = rp ? 0 : ((q.size() >= 2) ? 2 : q.size());
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         repeat (d) void'(q.pop_front());
         if (rdy) begin
            for (int k = 0; k < 4; k++) if (v[k]) q.push_back(UOP_W'(base + k));
         end
      end
      $display("cycle t=%0t in_valid=%b base=%0d rename_pause=%b flush=%b -> occupancy=%0d pause_req=%b",
               $time, v, base, rp, fl, occupancy, pause_req);
   endtask

   initial begin
      #12;
      chk("reset out_valid0", UOP_W'(out_valid0), '0);
      chk("reset out_valid1", UOP_W'(out_valid1), '0);
      chk("reset pause_req", UOP_W'(pause_req), '0);
      chk("reset occupancy", UOP_W'(occupancy), '0);
      @(negedge clk);
      #2;
      rst    = 1'b0;
      chk_en = 1'b1;

      // Burst compaction
      step(4'b1111, 10, 1'b0, 1'b0);
      chk("burst occ", UOP_W'(occupancy), 4);
      chk("burst uop0", out_uop0, 10);
      chk("burst uop1", out_uop1, 11);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("burst2 uop0", out_uop0, 12);
      chk("burst2 uop1", out_uop1, 13);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("burst empty", UOP_W'(out_valid0), 0);

      // Sparse slots
      step(4'b0101, 100, 1'b0, 1'b0);
      chk("sparse occ", UOP_W'(occupancy), 2);
      chk("sparse uop0", out_uop0, 100);
      chk("sparse uop1", out_uop1, 102);
      step(4'b1000, 100, 1'b0, 1'b0);
      chk("sparse C", out_uop0, 103);
      chk("sparse C v1", UOP_W'(out_valid1), 0);
      step(4'b0000, 0, 1'b0, 1'b0);

      // Backpressure
      step(4'b1111, 200, 1'b1, 1'b0);
      chk("bp occ4", UOP_W'(occupancy), 4);
      chk("bp pause0", UOP_W'(pause_req), 0);
      step(4'b1111, 204, 1'b1, 1'b0);
      chk("bp occ8", UOP_W'(occupancy), 8);
      chk("bp pause1", UOP_W'(pause_req), 1);
      step(4'b1111, 208, 1'b1, 1'b0);
      chk("bp ignored", UOP_W'(occupancy), 8);
      chk("bp head", out_uop0, 200);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("bp occ6", UOP_W'(occupancy), 6);
      chk("bp pause6", UOP_W'(pause_req), 1);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("bp occ4 drain", UOP_W'(occupancy), 4);
      chk("bp pause drop", UOP_W'(pause_req), 0);
      chk("bp order", out_uop0, 204);
      step(4'b0000, 0, 1'b0, 1'b0);
      step(4'b0000, 0, 1'b0, 1'b0);

      // Odd drain
      step(4'b0111, 300, 1'b0, 1'b0);
      chk("odd occ3", UOP_W'(occupancy), 3);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("odd v0", UOP_W'(out_valid0), 1);
      chk("odd v1", UOP_W'(out_valid1), 0);
      chk("odd uop", out_uop0, 302);
      step(4'b0000, 0, 1'b0, 1'b0);

      // Wrap-around with random traffic
      for (int i = 0; i < 20; i++) begin
         step(4'($urandom_range(0, 15)), 1000 + 16 * i, 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (5) step(4'b0000, 0, 1'b0, 1'b0);
      chk("wrap drained", UOP_W'(occupancy), 0);

      // Flush beats a same-cycle enqueue
      step(4'b1111, 400, 1'b1, 1'b0);
      step(4'b0011, 404, 1'b1, 1'b0);
      chk("flush pre occ", UOP_W'(occupancy), 6);
      step(4'b1111, 500, 1'b0, 1'b1);
      chk("flush occ", UOP_W'(occupancy), 0);
      chk("flush v0", UOP_W'(out_valid0), 0);
      step(4'b0000, 0, 1'b0, 1'b0);
      chk("flush not enq", UOP_W'(occupancy), 0);

      // Asynchronous reset mid-cycle
      step(4'b1111, 600, 1'b1, 1'b0);
      chk("rst pre occ", UOP_W'(occupancy), 4);
      chk_en = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("async rst v0", UOP_W'(out_valid0), 0);
      chk("async rst v1", UOP_W'(out_valid1), 0);
      chk("async rst occ", UOP_W'(occupancy), 0);
      chk("async rst pause", UOP_W'(pause_req), 0);
      q.delete();
      @(negedge clk);
      #2;
      rst    = 1'b0;
      chk_en = 1'b1;
      step(4'b1111, 700, 1'b0, 1'b0);
      chk("post rst uop0", out_uop0, 700);
      step(4'b0000, 0, 1'b0, 1'b0);
      step(4'b0000, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
